ysyx_25030093_isram: RTL and testbench

YSYX_25030093_ISRAM -- requirements
Module: ysyx_25030093_isram

---
 rtl/ysyx_25030093_isram.sv | 181 ++++++++++++++++++
 tb/tb_ysyx_25030093_isram.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030093_isram.sv
// ysyx_25030093_isram: instruction SRAM behind an AR/R read channel, with a backdoor write port for program load.
// Optional macro ISRAM_RAND_DELAY_EN replaces the fixed LATENCY with an LFSR-driven delay of 1..16 cycles.
module ysyx_25030093_isram #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic        init_we,
  input  logic [31:0] init_addr,
  input  logic [31:0] init_wdata
);

  localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
`ifdef ISRAM_RAND_DELAY_EN
  localparam int unsigned CNT_W = 5;
`else
  localparam int unsigned CNT_W = 4;
`endif
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, load_s;
  logic             arready_r, arready_s;
  logic             rvalid_r, rvalid_s;
  logic [31:0]      rdata_r;
  logic [1:0]       rresp_r;
  logic [31:0]      mem_r [MEM_WORDS];
  logic             ar_hs_s, ar_hit_s, init_hit_s;
  logic [31:0]      ar_off_s, init_off_s, ar_word_s;

  // Addresses below BASE wrap the offset far above MEM_BYTES, so both bounds are checked explicitly.
  function automatic logic addr_hit(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return (addr >= BASE) && ({1'b0, off} < MEM_BYTES);
  endfunction

  assign ar_off_s   = araddr - BASE;
  assign init_off_s = init_addr - BASE;
  assign ar_hit_s   = addr_hit(araddr);
  assign init_hit_s = addr_hit(init_addr);
  assign ar_hs_s    = arvalid && arready_r;

`ifdef ISRAM_RAND_DELAY_EN
  logic [7:0] lfsr_r;

  // Fibonacci LFSR (taps 8,6,5,4), free-running outside reset
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= 8'h5A;
    end else begin
      lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    end
  end

  assign load_s = {1'b0, lfsr_r[3:0]};
`else
  assign load_s = CNT_W'(LATENCY - 32'd1);
`endif

  // Word fetched at the handshake edge; out-of-range requests read as zero
  always_comb begin
    if (ar_hit_s) begin
      ar_word_s = mem_r[ar_off_s[IDX_W+1:2]];
    end else begin
      ar_word_s = 32'h0;
    end
  end

  // Next-state and delay counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (ar_hs_s) begin
          cnt_s   = load_s;
          state_s = (load_s == CNT_ZERO) ? RESP : WAIT;
        end else begin
          cnt_s   = cnt_r;
          state_s = IDLE;
        end
      end
      WAIT: begin
        cnt_s = cnt_r - CNT_ONE;
        if (cnt_r <= CNT_ONE) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        cnt_s = CNT_ZERO;
        if (rready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        cnt_s   = CNT_ZERO;
        state_s = IDLE;
      end
    endcase
  end

  // Handshake outputs for the upcoming state, registered below
  always_comb begin
    arready_s = 1'b1;
    rvalid_s  = 1'b0;
    case (state_s)
      IDLE: begin
        arready_s = 1'b1;
        rvalid_s  = 1'b0;
      end
      WAIT: begin
        arready_s = 1'b0;
        rvalid_s  = 1'b0;
      end
      RESP: begin
        arready_s = 1'b0;
        rvalid_s  = 1'b1;
      end
      default: begin
        arready_s = 1'b1;
        rvalid_s  = 1'b0;
      end
    endcase
  end

  // State, counter and response registers; response is frozen at the AR handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'h0;
      rresp_r   <= 2'b00;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      arready_r <= arready_s;
      rvalid_r  <= rvalid_s;
      if (ar_hs_s) begin
        rdata_r <= ar_word_s;
        rresp_r <= ar_hit_s ? 2'b00 : 2'b11;
      end
    end
  end

  // Backdoor program load; memory is deliberately left untouched by reset
  always_ff @(posedge clk) begin
    if (init_we && init_hit_s) begin
      mem_r[init_off_s[IDX_W+1:2]] <= init_wdata;
    end
  end

  assign arready = arready_r;
  assign rvalid  = rvalid_r;
  assign rdata   = rdata_r;
  assign rresp   = rresp_r;

endmodule

// File: tb/tb_ysyx_25030093_isram.sv
// Bench for ysyx_25030093_isram: two instances (LATENCY 1 and 4) sharing the backdoor bus,
// table-driven directed reads, reset corner cases, then randomized reads against an array model.
module tb_ysyx_25030093_isram;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  arvalid, arready, rvalid, rready;
  logic [31:0] araddr [2];
  logic [31:0] rdata  [2];
  logic [1:0]  rresp  [2];
  logic        init_we;
  logic [31:0] init_addr, init_wdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [WORDS];

  typedef struct {
    int          u;
    logic [31:0] addr;
    int          hold;
    bit          poke;
    bit          noise;
    logic [1:0]  exp_resp;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  ysyx_25030093_isram #(.MEM_WORDS(WORDS), .BASE(BASE), .LATENCY(1)) dut0 (
    .clk(clk), .rst(rst), .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
    .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata));

  ysyx_25030093_isram #(.MEM_WORDS(WORDS), .BASE(BASE), .LATENCY(4)) dut1 (
    .clk(clk), .rst(rst), .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
    .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata));

  function automatic bit in_rng(input logic [31:0] a);
    if (a < BASE) return 1'b0;
    return (a - BASE) < 32'(WORDS * 4);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (!in_rng(a)) return 32'h0;
    return model[(a - BASE) >> 2];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    init_we = 1'b0;
  endtask

  task automatic bd_set(input logic [31:0] a, input logic [31:0] d);
    init_we    = 1'b1;
    init_addr  = a;
    init_wdata = d;
    if (in_rng(a)) model[(a - BASE) >> 2] = d;
  endtask

  task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
    bd_set(a, d);
    step();
  endtask

  task automatic do_read(input int u, input logic [31:0] a, input int hold, input bit poke,
                         input bit noise, input logic [1:0] exp_r, input int lo, input int hi,
                         input string nm);
    logic [31:0] exp_d;
    logic [31:0] held;
    int lat;
    exp_d = exp_word(a);
    chk({nm, "_arready_idle"}, {31'd0, arready[u]}, 32'd1);
    araddr[u]  = a;
    arvalid[u] = 1'b1;
    rready[u]  = (hold == 0);
    step();
    if (noise) araddr[u] = a ^ 32'h0000_0040;
    else arvalid[u] = 1'b0;
    if (poke) bd_set(a, ~exp_d);
    lat = 1;
    while (rvalid[u] !== 1'b1 && lat < 40) begin
      chk({nm, "_arready_wait"}, {31'd0, arready[u]}, 32'd0);
      step();
      lat++;
    end
    chk_rng({nm, "_latency"}, lat, lo, hi);
    chk({nm, "_rdata"}, rdata[u], exp_d);
    chk({nm, "_rresp"}, {30'd0, rresp[u]}, {30'd0, exp_r});
    held = rdata[u];
    for (int i = 0; i < hold; i++) begin
      step();
      chk({nm, "_rvalid_hold"}, {31'd0, rvalid[u]}, 32'd1);
      chk({nm, "_rdata_hold"}, rdata[u], held);
    end
    rready[u] = 1'b1;
    step();
    chk({nm, "_rvalid_done"}, {31'd0, rvalid[u]}, 32'd0);
    chk({nm, "_arready_done"}, {31'd0, arready[u]}, 32'd1);
    arvalid[u] = 1'b0;
    rready[u]  = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int          u, lo, hi, r, hold;
    bit          seen;
    logic [31:0] a;

    rst = 1'b1;
    arvalid = 2'b00;
    rready = 2'b00;
    araddr[0] = 32'h0;
    araddr[1] = 32'h0;
    init_we = 1'b0;
    init_addr = 32'h0;
    init_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_arready", {31'd0, arready[k]}, 32'd1);
      chk("reset_rvalid", {31'd0, rvalid[k]}, 32'd0);
      chk("reset_rdata", rdata[k], 32'h0);
      chk("reset_rresp", {30'd0, rresp[k]}, 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < WORDS; i++) bd_write(BASE + 32'(4 * i), $urandom);
    bd_write(BASE, 32'h0010_0093);

    vecs[0]  = '{0, 32'h8000_0000, 0, 1'b0, 1'b0, 2'b00, 1, "first_fetch"};
    vecs[1]  = '{1, 32'h8000_0004, 0, 1'b0, 1'b0, 2'b00, 4, "lat4_read"};
    vecs[2]  = '{0, 32'h7FFF_FFFC, 0, 1'b0, 1'b0, 2'b11, 1, "below_base"};
    vecs[3]  = '{1, 32'h8000_1000, 0, 1'b0, 1'b0, 2'b11, 4, "past_top"};
    vecs[4]  = '{0, 32'h8000_0FFC, 0, 1'b0, 1'b0, 2'b00, 1, "last_word"};
    vecs[5]  = '{1, 32'h8000_0FFF, 1, 1'b0, 1'b0, 2'b00, 4, "unaligned_last"};
    vecs[6]  = '{0, 32'h8000_0002, 5, 1'b0, 1'b0, 2'b00, 1, "rready_hold5"};
    vecs[7]  = '{1, 32'h8000_0010, 2, 1'b1, 1'b0, 2'b00, 4, "poke_pending"};
    vecs[8]  = '{0, 32'h8000_0014, 0, 1'b1, 1'b0, 2'b00, 1, "poke_lat1"};
    vecs[9]  = '{1, 32'h8000_0020, 0, 1'b0, 1'b1, 2'b00, 4, "arvalid_held"};
    vecs[10] = '{0, 32'h0000_0000, 0, 1'b0, 1'b1, 2'b11, 1, "zero_addr"};
    vecs[11] = '{1, 32'hFFFF_FFFC, 3, 1'b0, 1'b0, 2'b11, 4, "top_of_space"};

    for (int i = 0; i < 12; i++) begin
`ifdef ISRAM_RAND_DELAY_EN
      lo = 1;
      hi = 16;
`else
      lo = vecs[i].exp_lat;
      hi = vecs[i].exp_lat;
`endif
      do_read(vecs[i].u, vecs[i].addr, vecs[i].hold, vecs[i].poke, vecs[i].noise,
              vecs[i].exp_resp, lo, hi, vecs[i].name);
    end

    // Out-of-range backdoor writes must not alias onto real words
    bd_write(32'h8000_1000, 32'hDEAD_BEEF);
    bd_write(32'h7FFF_FFFC, 32'hCAFE_F00D);
    chk("model_word0", model[0], 32'h0010_0093);
    do_read(0, BASE, 0, 1'b0, 1'b0, 2'b00, 1, 16, "oob_write_ignored");

    // Reset while the LATENCY-4 unit is waiting
    araddr[1] = BASE + 32'd8;
    arvalid[1] = 1'b1;
    rready[1] = 1'b1;
    step();
    arvalid[1] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_wait_arready", {31'd0, arready[1]}, 32'd1);
    chk("rst_wait_rvalid", {31'd0, rvalid[1]}, 32'd0);
    chk("rst_wait_rdata", rdata[1], 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen |= rvalid[1];
    end
    chk("rst_wait_no_resp", {31'd0, seen}, 32'd0);
    rready[1] = 1'b0;

    // Reset while the LATENCY-1 unit holds a response
    araddr[0] = BASE + 32'd12;
    arvalid[0] = 1'b1;
    rready[0] = 1'b0;
    step();
    arvalid[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_resp_arready", {31'd0, arready[0]}, 32'd1);
    chk("rst_resp_rvalid", {31'd0, rvalid[0]}, 32'd0);
    chk("rst_resp_rresp", {30'd0, rresp[0]}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= rvalid[0];
    end
    chk("rst_resp_no_resp", {31'd0, seen}, 32'd0);
    do_read(0, BASE, 0, 1'b0, 1'b0, 2'b00, 1, 16, "mem_survives_reset");

    // Randomized reads against the array model
    for (int k = 0; k < 150; k++) begin
      u = int'($urandom_range(1, 0));
      r = int'($urandom_range(9, 0));
      if (r < 7) a = BASE + 32'($urandom_range(WORDS * 4 - 1, 0));
      else if (r == 7) a = $urandom;
      else a = BASE + 32'(WORDS * 4) + 32'($urandom_range(64, 0));
      if ($urandom_range(3, 0) == 0) bd_write(BASE + 32'(4 * $urandom_range(WORDS - 1, 0)), $urandom);
      hold = int'($urandom_range(3, 0));
`ifdef ISRAM_RAND_DELAY_EN
      lo = 1;
      hi = 16;
`else
      lo = (u == 0) ? 1 : 4;
      hi = lo;
`endif
      do_read(u, a, hold, $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0,
              in_rng(a) ? 2'b00 : 2'b11, lo, hi, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
